regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised, clocked register file for the MIPS pipeline, replacing the combinational latch-style register array. It provides NUM_READ read ports and one write port. Optional hardwired zero register and optional write-to-read bypass are selected by parameter. An integrated scoreboard tracks registers with an in-flight producer, so decode can detect RAW hazards.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of registers (power of two, >=2)
ADDR_W, $clog2(DEPTH), register address width (derived, not overridden)
NUM_READ, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data and busy-clear forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  reset, synchronous, active-high
rd_addr  in  NUM_READ*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_READ*WIDTH  packed read data, port k at [k*WIDTH +: WIDTH]
rd_busy  out  NUM_READ  per-port: addressed register has a pending producer
wr_en  in  1  write strobe (writeback stage)
wr_addr  in  ADDR_W  write address
wr_data  in  WIDTH  write data
issue_en  in  1  mark issue_addr as pending (an instruction with a destination issued)
issue_addr  in  ADDR_W  destination being issued
busy_count  out  ADDR_W+1  number of registers currently marked busy

Behaviour:
- Storage: regs[DEPTH] of WIDTH bits, plus busy[DEPTH] bits.
- Reset (sampled at posedge, reset=1): all regs <= 0, all busy <= 0. Reset overrides wr_en and issue_en in the same cycle.
- Outputs are combinational from state and inputs, so their values follow from the state:
  - After reset: rd_data = 0 (all ports), rd_busy = 0, busy_count = 0.
  - A reset asserted mid-operation discards all pending busy bits and data on that edge.
- Write: on posedge with wr_en=1, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - ZERO_REG=1 and wr_addr=0: the write is dropped; reg 0 stays 0.
- Issue: on posedge with issue_en=1, busy[issue_addr] <= 1.
  - ZERO_REG=1 and issue_addr=0: ignored.
  - Issue to a register that is already busy (WAW): remains busy, no error.
- Simultaneous wr_en and issue_en to the same address in one cycle:
  - Data is written.
  - busy ends at 1, because issue wins: the new producer supersedes the completing one.
- Read data, per port k, with A = rd_addr[k]:
  - ZERO_REG=1 and A=0: rd_data = 0.
  - Else if BYPASS=1, wr_en=1, wr_addr=A, and the write is not dropped: rd_data = wr_data (same cycle).
  - Else: rd_data = regs[A].
  - BYPASS=0: the new value is visible from the cycle after the write edge.
- Read busy, per port k:
  - rd_busy = busy[A].
  - If BYPASS=1, wr_en=1, and wr_addr=A: rd_busy = 0, regardless of busy[A].
  - Always 0 for A=0 when ZERO_REG=1.
  - A same-cycle issue does not affect rd_busy until the next cycle.
- Read ports may alias each other and the write address freely; all ports resolve independently.
- busy_count: population count of busy[], range 0..DEPTH (or DEPTH-1 with ZERO_REG). It is computed from registered state only, so it updates the cycle after an issue or write.
- Latency: write-to-read 0 cycles with BYPASS=1, 1 cycle without. Issue-to-busy 1 cycle.
- No X propagation: all storage is defined after the first reset edge. Reads before any reset are undefined and not checked.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH/DEPTH constants;
  - a function for the ADDR_W calculation;
  - a popcount function for busy_count;
  - the MIPS register index constants (ZERO=0, RA=31).
- One natural sub-module, regfile_read_port: the per-port mux containing the zero check, write bypass and busy-mask logic. Instantiate it NUM_READ times in a generate loop.
- Storage, scoreboard and busy_count stay in the top.

Test Plan:
1. Reset → all 32 regs read 0 on both ports, busy_count=0. Then wr_en, addr 4, data 32'h0000000F; rd_addr0=4 in the same cycle → rd_data0=32'hF (BYPASS=1), and 32'hF on the following cycle.
2. wr_en, addr 0, data 32'hDEADBEEF; issue_addr=0 → rd_data for addr 0 stays 0, rd_busy=0, busy_count=0.
3. issue addr 7 → next cycle rd_busy=1 for addr 7, busy_count=1. wr_en addr 7, data 32'h55 that cycle → rd_busy=0 and rd_data=32'h55 in the same cycle, busy_count=0 on the next cycle.
4. Same cycle: issue and write both to addr 9 (data 32'h1) → regs[9]=1, busy[9]=1, busy_count=1. A later write to addr 9 (data 32'h2) clears it.
5. Issue addrs 1..5 over five cycles, then assert reset in the middle of the pending writes → busy_count=0 and all rd_data=0 on the next cycle. A write issued in the reset cycle is dropped.
6. Rerun with NUM_READ=3, BYPASS=0, WIDTH=16, DEPTH=16:
   - Three ports all read addr 3 while it is written with 16'hA5A5: all three show the old value that cycle and 16'hA5A5 the next.
   - busy_count width is 5 bits.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the scoreboarded register file
//
// Purpose: default geometry, MIPS register indices, address-width and popcount
//          helpers used by regfile_sb and regfile_read_port.
// Ports:   none (package).
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  // Widest scoreboard the popcount helper accepts.
  localparam int MAX_DEPTH = 256;

  // MIPS register indices.
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int popcount(input logic [MAX_DEPTH-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one read port: zero register, write bypass, busy masking
//
// Purpose: resolves read data and busy for one address from the stored
//          value/busy bit and the current write-port activity.
// Ports:   i_addr      read address
//          i_reg_data  stored value of the addressed register
//          i_reg_busy  stored busy bit of the addressed register
//          i_wr_en/i_wr_addr/i_wr_data  current write port
//          o_data      resolved read data
//          o_busy      resolved pending-producer flag
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_reg_data,
  input  logic              i_reg_busy,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_busy
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (ZERO_REG != 0) && (i_addr == '0);
  assign w_hit     = (BYPASS != 0) && i_wr_en && (i_wr_addr == i_addr);

  // The zero check is tested first, so a dropped write to reg 0 never bypasses.
  always_comb begin
    o_data = i_reg_data;
    o_busy = i_reg_busy;
    if (w_is_zero) begin
      o_data = '0;
      o_busy = 1'b0;
    end else if (w_hit) begin
      o_data = i_wr_data;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - clocked register file with integrated RAW scoreboard
//
// Purpose: NUM_READ read ports, one write port, busy bit per register set at
//          issue and cleared at writeback, plus a count of busy registers.
// Ports:   clk, reset (synchronous, active-high)
//          rd_addr/rd_data/rd_busy  packed per-port read address, data, busy
//          wr_en/wr_addr/wr_data    writeback port
//          issue_en/issue_addr      mark a destination as pending
//          busy_count               number of busy registers (registered state)
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NUM_READ = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = addr_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ*WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]        rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic [ADDR_W:0]            busy_count
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic w_wr_go;
  logic w_issue_go;

  assign w_wr_go    = wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_issue_go = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

  // The issue update follows the write update so a same-address issue wins:
  // the newly issued producer supersedes the one completing this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_go) begin
        r_regs[wr_addr] <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_issue_go) begin
        r_busy[issue_addr] <= 1'b1;
      end
    end
  end

  assign busy_count = (ADDR_W+1)'(popcount(MAX_DEPTH'(r_busy)));

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .i_addr     (w_addr),
      .i_reg_data (r_regs[w_addr]),
      .i_reg_busy (r_busy[w_addr]),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .o_data     (rd_data[k*WIDTH +: WIDTH]),
      .o_busy     (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Default configuration: 32x32, 2 ports, zero reg, bypass.
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_issue_en;
  logic [4:0]  a_issue_addr;
  logic [5:0]  a_busy_count;

  // Second configuration: 16x16, 3 ports, zero reg, no bypass.
  logic [11:0] b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_issue_en;
  logic [3:0]  b_issue_addr;
  logic [4:0]  b_busy_count;

  regfile_sb #(
    .WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (a_rd_addr),
    .rd_data    (a_rd_data),
    .rd_busy    (a_rd_busy),
    .wr_en      (a_wr_en),
    .wr_addr    (a_wr_addr),
    .wr_data    (a_wr_data),
    .issue_en   (a_issue_en),
    .issue_addr (a_issue_addr),
    .busy_count (a_busy_count)
  );

  regfile_sb #(
    .WIDTH(16), .DEPTH(16), .NUM_READ(3), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (b_rd_addr),
    .rd_data    (b_rd_data),
    .rd_busy    (b_rd_busy),
    .wr_en      (b_wr_en),
    .wr_addr    (b_wr_addr),
    .wr_data    (b_wr_data),
    .issue_en   (b_issue_en),
    .issue_addr (b_issue_addr),
    .busy_count (b_busy_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_read(input logic [4:0] p0, input logic [4:0] p1);
    a_rd_addr = {p1, p0};
  endtask

  initial begin
    reset        = 1'b1;
    a_rd_addr    = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    a_issue_en   = 1'b0; a_issue_addr = '0;
    b_rd_addr    = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_issue_en   = 1'b0; b_issue_addr = '0;
    step();
    step();
    reset = 1'b0;
    #1;

    // 1. reset state, then bypassed write to reg 4
    for (int a = 0; a < 32; a++) begin
      a_read(5'(a), 5'(a));
      #1;
      check($sformatf("rst_data0_r%0d", a), a_rd_data[31:0], 32'h0);
      check($sformatf("rst_data1_r%0d", a), a_rd_data[63:32], 32'h0);
    end
    check("rst_busy", {30'b0, a_rd_busy}, 32'h0);
    check("rst_count", {26'b0, a_busy_count}, 32'h0);

    a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h0000000F;
    a_read(5'd4, 5'd5);
    #1;
    check("byp_w4_p0", a_rd_data[31:0], 32'hF);
    check("byp_w4_p1", a_rd_data[63:32], 32'h0);
    step();
    a_wr_en = 1'b0;
    #1;
    check("w4_next", a_rd_data[31:0], 32'hF);

    // 2. write and issue to reg 0 are ignored
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hDEADBEEF;
    a_issue_en = 1'b1; a_issue_addr = 5'd0;
    a_read(5'd0, 5'd0);
    #1;
    check("zero_same_data", a_rd_data[31:0], 32'h0);
    check("zero_same_busy", {31'b0, a_rd_busy[0]}, 32'h0);
    step();
    a_wr_en = 1'b0; a_issue_en = 1'b0;
    #1;
    check("zero_next_data", a_rd_data[31:0], 32'h0);
    check("zero_next_busy", {31'b0, a_rd_busy[0]}, 32'h0);
    check("zero_next_count", {26'b0, a_busy_count}, 32'h0);

    // 3. issue 7, then writeback clears busy with bypass
    a_issue_en = 1'b1; a_issue_addr = 5'd7;
    a_read(5'd7, 5'd4);
    #1;
    check("iss7_same_busy", {31'b0, a_rd_busy[0]}, 32'h0);
    step();
    a_issue_en = 1'b0;
    #1;
    check("iss7_busy", {31'b0, a_rd_busy[0]}, 32'h1);
    check("iss7_count", {26'b0, a_busy_count}, 32'h1);
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h55;
    #1;
    check("wb7_same_busy", {31'b0, a_rd_busy[0]}, 32'h0);
    check("wb7_same_data", a_rd_data[31:0], 32'h55);
    check("wb7_same_count", {26'b0, a_busy_count}, 32'h1);
    step();
    a_wr_en = 1'b0;
    #1;
    check("wb7_next_count", {26'b0, a_busy_count}, 32'h0);
    check("wb7_next_busy", {31'b0, a_rd_busy[0]}, 32'h0);
    check("wb7_next_data", a_rd_data[31:0], 32'h55);

    // 4. simultaneous issue and write to 9: data lands, issue wins busy
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h1;
    a_issue_en = 1'b1; a_issue_addr = 5'd9;
    a_read(5'd4, 5'd9);
    #1;
    check("ww9_same_data", a_rd_data[63:32], 32'h1);
    check("ww9_same_busy", {31'b0, a_rd_busy[1]}, 32'h0);
    step();
    a_wr_en = 1'b0; a_issue_en = 1'b0;
    #1;
    check("ww9_data", a_rd_data[63:32], 32'h1);
    check("ww9_busy", {31'b0, a_rd_busy[1]}, 32'h1);
    check("ww9_count", {26'b0, a_busy_count}, 32'h1);
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h2;
    step();
    a_wr_en = 1'b0;
    #1;
    check("w9b_data", a_rd_data[63:32], 32'h2);
    check("w9b_busy", {31'b0, a_rd_busy[1]}, 32'h0);
    check("w9b_count", {26'b0, a_busy_count}, 32'h0);

    // WAW issue to RA stays a single busy register
    a_issue_en = 1'b1; a_issue_addr = 5'd31;
    step();
    step();
    a_issue_en = 1'b0;
    a_read(5'd31, 5'd31);
    #1;
    check("waw31_busy", {31'b0, a_rd_busy[0]}, 32'h1);
    check("waw31_count", {26'b0, a_busy_count}, 32'h1);
    a_wr_en = 1'b1; a_wr_addr = 5'd31; a_wr_data = 32'hCAFE0031;
    step();
    a_wr_en = 1'b0;
    #1;
    check("w31_count", {26'b0, a_busy_count}, 32'h0);
    check("w31_data", a_rd_data[63:32], 32'hCAFE0031);

    // 5. issue 1..5, then reset with a write and issue pending
    for (int r = 1; r <= 5; r++) begin
      a_issue_en = 1'b1; a_issue_addr = 5'(r);
      step();
    end
    a_issue_en = 1'b0;
    a_read(5'd3, 5'd5);
    #1;
    check("pend_count", {26'b0, a_busy_count}, 32'h5);
    check("pend_busy", {30'b0, a_rd_busy}, 32'h3);
    reset = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'h1234;
    a_issue_en = 1'b1; a_issue_addr = 5'd6;
    step();
    reset = 1'b0; a_wr_en = 1'b0; a_issue_en = 1'b0;
    #1;
    check("mrst_count", {26'b0, a_busy_count}, 32'h0);
    check("mrst_busy", {30'b0, a_rd_busy}, 32'h0);
    a_read(5'd4, 5'd7);
    #1;
    check("mrst_r4", a_rd_data[31:0], 32'h0);
    check("mrst_r7", a_rd_data[63:32], 32'h0);
    a_read(5'd9, 5'd10);
    #1;
    check("mrst_r9", a_rd_data[31:0], 32'h0);
    check("mrst_r10", a_rd_data[63:32], 32'h0);
    a_read(5'd6, 5'd31);
    #1;
    check("mrst_busy6", {31'b0, a_rd_busy[0]}, 32'h0);
    check("mrst_r31", a_rd_data[63:32], 32'h0);

    // 6. no-bypass configuration, three ports aliasing reg 3
    b_wr_en = 1'b1; b_wr_addr = 4'd3; b_wr_data = 16'h1111;
    step();
    b_rd_addr = {4'd3, 4'd3, 4'd3};
    b_wr_data = 16'hA5A5;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("nb_old_p%0d", k), {16'b0, b_rd_data[k*16 +: 16]}, 32'h1111);
    end
    step();
    b_wr_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("nb_new_p%0d", k), {16'b0, b_rd_data[k*16 +: 16]}, 32'hA5A5);
    end

    // busy is not masked by a same-cycle write without bypass
    b_issue_en = 1'b1; b_issue_addr = 4'd15;
    step();
    b_issue_en = 1'b0;
    b_rd_addr = {4'd0, 4'd3, 4'd15};
    #1;
    check("nb_count15", {27'b0, b_busy_count}, 32'h1);
    check("nb_busy15", {29'b0, b_rd_busy}, 32'h1);
    b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 16'h0F0F;
    #1;
    check("nb_wb_same_busy", {29'b0, b_rd_busy}, 32'h1);
    check("nb_wb_same_data", {16'b0, b_rd_data[15:0]}, 32'h0);
    step();
    b_wr_en = 1'b0;
    #1;
    check("nb_wb_busy", {29'b0, b_rd_busy}, 32'h0);
    check("nb_wb_data", {16'b0, b_rd_data[15:0]}, 32'h0F0F);
    check("nb_wb_count", {27'b0, b_busy_count}, 32'h0);
    check("nb_p2_zero", {16'b0, b_rd_data[47:32]}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
